// File: rtl/hazard_unit_nwide.sv
// Hazard/stall controller for an N-issue in-order pipeline.
// Detects load-use, branch/JR/BEX operand, intra-bundle RAW and multdiv
// scoreboard hazards; drives latch enables, per-lane bubbles and a split mask.
// An F/D lane is taken to write its fd_rd unless it is a branch, JR or BEX.
module hazard_unit_nwide #(
    parameter int LANES    = 2,
    parameter int REG_BITS = 5,
    parameter int CNT_W    = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [LANES*REG_BITS-1:0] fd_rs,
    input  logic [LANES*REG_BITS-1:0] fd_rt,
    input  logic [LANES*REG_BITS-1:0] fd_rd,
    input  logic [LANES-1:0]          fd_branch,
    input  logic [LANES-1:0]          fd_jr,
    input  logic [LANES-1:0]          fd_bex,
    input  logic [LANES*REG_BITS-1:0] dx_rd,
    input  logic [LANES-1:0]          dx_regwrite,
    input  logic [LANES-1:0]          dx_memread,
    input  logic [LANES*REG_BITS-1:0] xm_rd,
    input  logic [LANES-1:0]          xm_memread,
    input  logic                      md_issue,
    input  logic [REG_BITS-1:0]       md_issue_rd,
    input  logic                      md_done,
    input  logic [REG_BITS-1:0]       md_done_rd,
    output logic                      pc_write,
    output logic                      fd_write,
    output logic                      dx_write,
    output logic                      xm_write,
    output logic [LANES-1:0]          bubble,
    output logic [LANES-1:0]          split,
    output logic                      md_busy,
    output logic [CNT_W-1:0]          stall_cycles
);

    localparam int NREGS = 2 ** REG_BITS;
    localparam logic [REG_BITS-1:0] R30 = REG_BITS'(30);

    logic [REG_BITS-1:0] rs_l   [LANES];
    logic [REG_BITS-1:0] rt_l   [LANES];
    logic [REG_BITS-1:0] rd_l   [LANES];
    logic [REG_BITS-1:0] dxrd_l [LANES];
    logic [REG_BITS-1:0] xmrd_l [LANES];

    logic [NREGS-1:0] sb_q;
    logic [NREGS-1:0] sb_next;
    logic             raw_stall;
    logic [LANES-1:0] split_raw;
    logic             stall_q;
    logic [LANES-1:0] split_q;
    logic             md_wait_q;
    logic             lane_raw;
    logic             found;

    function automatic logic hit(input logic [REG_BITS-1:0] a,
                                 input logic [REG_BITS-1:0] b);
        return (a == b) && (a != '0);
    endfunction

    // Unpack per-lane register specifiers
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            rs_l[i]   = fd_rs[i*REG_BITS +: REG_BITS];
            rt_l[i]   = fd_rt[i*REG_BITS +: REG_BITS];
            rd_l[i]   = fd_rd[i*REG_BITS +: REG_BITS];
            dxrd_l[i] = dx_rd[i*REG_BITS +: REG_BITS];
            xmrd_l[i] = xm_rd[i*REG_BITS +: REG_BITS];
        end
    end

    // Full-stall detection over every F/D lane against every producer lane
    always_comb begin
        raw_stall = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (sb_q[rs_l[i]] || sb_q[rt_l[i]] || sb_q[rd_l[i]])
                raw_stall = 1'b1;
            for (int unsigned j = 0; j < LANES; j++) begin
                if (dx_memread[j] && (hit(dxrd_l[j], rs_l[i]) || hit(dxrd_l[j], rt_l[i])))
                    raw_stall = 1'b1;
                if (dx_regwrite[j] &&
                    ((fd_branch[i] && (hit(dxrd_l[j], rd_l[i]) || hit(dxrd_l[j], rs_l[i]))) ||
                     (fd_jr[i] && hit(dxrd_l[j], rd_l[i]))))
                    raw_stall = 1'b1;
                if (xm_memread[j] &&
                    ((fd_branch[i] && (hit(xmrd_l[j], rd_l[i]) || hit(xmrd_l[j], rs_l[i]))) ||
                     (fd_jr[i] && hit(xmrd_l[j], rd_l[i]))))
                    raw_stall = 1'b1;
                if (fd_bex[i] && ((dx_regwrite[j] && dxrd_l[j] == R30) ||
                                  (xm_memread[j] && xmrd_l[j] == R30)))
                    raw_stall = 1'b1;
            end
        end
    end

    // Intra-bundle RAW: first dependent lane and all younger lanes are split off
    always_comb begin
        split_raw = '0;
        found     = 1'b0;
        lane_raw  = 1'b0;
        for (int unsigned i = 1; i < LANES; i++) begin
            lane_raw = 1'b0;
            for (int unsigned k = 0; k < i; k++) begin
                if (!(fd_branch[k] || fd_jr[k] || fd_bex[k]) &&
                    (hit(rd_l[k], rs_l[i]) || hit(rd_l[k], rt_l[i]) ||
                     ((fd_branch[i] || fd_jr[i]) && hit(rd_l[k], rd_l[i]))))
                    lane_raw = 1'b1;
            end
            if (lane_raw)
                found = 1'b1;
            if (found)
                split_raw[i] = 1'b1;
        end
        if (raw_stall)
            split_raw = '0;
    end

    // Scoreboard next state: clear first so a same-register issue wins
    always_comb begin
        sb_next = sb_q;
        if (md_done)
            sb_next[md_done_rd] = 1'b0;
        if (md_issue && md_issue_rd != '0)
            sb_next[md_issue_rd] = 1'b1;
    end

    // Scoreboard register, rising edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            sb_q <= '0;
        else
            sb_q <= sb_next;
    end

    // Hazard decision registers, falling edge
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            stall_q   <= 1'b0;
            split_q   <= '0;
            md_wait_q <= 1'b0;
        end else begin
            stall_q   <= raw_stall;
            split_q   <= split_raw;
            md_wait_q <= md_busy && !md_done;
        end
    end

    // Saturating full-stall cycle counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (stall_q && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
    end

    // Output decode
    always_comb begin
        md_busy  = |sb_q;
        pc_write = !stall_q && !(|split_q);
        fd_write = pc_write;
        dx_write = !md_wait_q;
        xm_write = !md_wait_q;
        bubble   = md_wait_q ? '0 : ({LANES{stall_q}} | split_q);
    end

    generate
        if (LANES == 1) begin : g_no_split
            assign split = '0;
        end else begin : g_split
            assign split = split_q;
        end
    endgenerate

endmodule

// File: doc/hazard_unit_nwide.md
Name: hazard_unit_nwide

Overview:
- Parametrised hazard/stall controller for an N-issue in-order pipeline (F/D, D/X, X/M latches); successor to the fixed 2-lane hazard logic.
- Detects load-use, branch/JR/BEX operand, intra-bundle RAW and long-latency (multdiv) scoreboard hazards across all lanes.
- Drives PC/latch write enables, per-lane bubble injection and a bundle split mask.
- Holds a multdiv destination scoreboard and a saturating stall-cycle counter.

Parameters:
- LANES, 2, issue width (1..4); lane 0 is oldest.
- REG_BITS, 5, register specifier width; register 0 is never a hazard.
- CNT_W, 16, stall counter width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- fd_rs, fd_rt, fd_rd  in  LANES*REG_BITS each  F/D source/dest specifiers; lane i in bits [i*REG_BITS +: REG_BITS]
- fd_branch  in  LANES  lane i is a branch (reads rs, rd)
- fd_jr  in  LANES  lane i is JR (reads rd)
- fd_bex  in  LANES  lane i is BEX (reads r30)
- dx_rd  in  LANES*REG_BITS  D/X destinations
- dx_regwrite, dx_memread  in  LANES each  D/X lane writes reg / is load
- xm_rd  in  LANES*REG_BITS  X/M destinations
- xm_memread  in  LANES  X/M lane is load
- md_issue  in  1  multdiv entering X this cycle
- md_issue_rd  in  REG_BITS  its destination
- md_done  in  1  multdiv result ready (pulse)
- md_done_rd  in  REG_BITS  completing destination
- pc_write, fd_write  out  1  advance PC / F/D latch
- dx_write, xm_write  out  1  advance D/X / X/M latch
- bubble  out  LANES  insert nop into D/X lane i next edge
- split  out  LANES  lane i and younger held in F/D for the next cycle
- md_busy  out  1  any scoreboard bit set
- stall_cycles  out  CNT_W  saturating count of full-stall cycles

Behaviour:
- Match rule: a hazard requires equal specifiers and a nonzero producer register.
- Full stall conditions (raw_stall) are OR-ed over all lanes i (F/D) and j (producer):
  - load-use: dx_memread[j] and dx_rd[j] matches fd_rs[i] or fd_rt[i].
  - branch/JR: fd_branch[i] and dx_regwrite[j] and dx_rd[j] matches fd_rd[i] or fd_rs[i]; fd_jr[i] checks fd_rd[i] only.
  - branch/JR behind load: xm_memread[j] with the same operand rules against xm_rd[j].
  - BEX: fd_bex[i] and (dx_regwrite[j] and dx_rd[j]==30, or xm_memread[j] and xm_rd[j]==30).
  - scoreboard: the busy bit of fd_rs[i], fd_rt[i] or fd_rd[i] is set.
- Intra-bundle RAW: lane i>0 reads (rs/rt, or rd when branch/JR) a register written by an older F/D lane k<i.
  - split_raw has its lowest such i set, plus all younger lanes.
  - Applies only when raw_stall is 0.
- Registers, all sampled on the falling edge of clock, async cleared by reset:
  - stall_q <= raw_stall
  - split_q <= split_raw
  - md_wait_q <= md_busy and not md_done
- Outputs:
  - pc_write = fd_write = ~stall_q & ~(|split_q).
  - With split active, the PC is held; F/D reissues only split lanes, and the front end shifts them to lane 0.
  - bubble = {LANES{stall_q}} | split_q.
  - dx_write = xm_write = ~md_wait_q.
  - When md_wait_q is high, bubble is forced to 0, so control is suppressed while frozen.
- Scoreboard, 2^REG_BITS bits:
  - Set on rising edge when md_issue and md_issue_rd != 0.
  - Clear when md_done at md_done_rd.
  - Simultaneous set and clear of the same register: set wins, treated as a new issue.
  - md_busy = OR of all bits.
- stall_cycles increments on rising edge when stall_q is high; saturates at all-ones, no wrap.
- Reset values (asynchronous): scoreboard 0, stall_q 0, split_q 0, md_wait_q 0, stall_cycles 0.
  - Hence pc_write=fd_write=dx_write=xm_write=1, bubble=0, split=0, md_busy=0.
- Reset mid-stall or mid-multdiv drops all pending state immediately.
- LANES=1: split is tied 0.

Test Plan:
- Load-use: LANES=2; dx_memread[1]=1, dx_rd lane1=7, fd_rs lane0=7 -> after falling edge pc_write=fd_write=0, bubble=2'b11, stall_cycles 0->1 on next rising edge; clears next cycle once dx_memread=0.
- Zero register: same as the load-use case with register 0 -> no stall; pc_write stays 1, bubble=0.
- Intra-bundle: fd_rd lane0=4 with a regwrite op, fd_rs lane1=4, no other hazards -> split=2'b10, bubble=2'b10, pc_write=0 for one cycle.
- Scoreboard:
  - md_issue with rd=9, then fd_rt lane0=9 -> stall held each cycle until the md_done rd=9 cycle.
  - dx_write=xm_write=0 while md_wait_q is high; md_busy returns to 0 after md_done.
  - Simultaneous md_issue and md_done with rd=9 -> bit remains set.
- Saturation: CNT_W=4, hold a load-use stall for 20 cycles -> stall_cycles reaches 15 and stays 15.
- Async reset asserted mid-stall between edges -> outputs immediately return to reset values; scoreboard empty.
